// File: rtl/fdiv_seq_if.sv
// Handshake bundle for fdiv_seq: operand request channel and result channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface fdiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: 26-step restoring mantissa division,
// round-to-nearest-even, denormals flushed to zero, special operands resolved at acceptance.
module fdiv_seq #(
  parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rstn,
  fdiv_seq_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               sign_r;
  logic signed [9:0]  ediff_r;
  logic [23:0]        div_r;
  logic [24:0]        rem_r;
  logic [25:0]        q_r;
  logic [4:0]         cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [31:0]        y_r;
  logic               ovf_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state;

  // Operand decode straight from the inputs; only consumed on the accepting edge.
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        z1, z2, i1, i2, n1, n2, s_in;
  logic        sp_hit;
  logic [31:0] sp_y;

  always_comb begin
    e1   = bus.x1[30:23];
    e2   = bus.x2[30:23];
    m1   = bus.x1[22:0];
    m2   = bus.x2[22:0];
    s_in = bus.x1[31] ^ bus.x2[31];
    z1   = (e1 == 8'h00);
    z2   = (e2 == 8'h00);
    i1   = (e1 == 8'hFF) && (m1 == 23'd0);
    i2   = (e2 == 8'hFF) && (m2 == 23'd0);
    n1   = (e1 == 8'hFF) && (m1 != 23'd0);
    n2   = (e2 == 8'hFF) && (m2 != 23'd0);
    sp_hit = 1'b1;
    sp_y   = 32'd0;
    if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
      sp_y = NAN_OUT;
    end else if (i1 || z2) begin
      sp_y = {s_in, 8'hFF, 23'd0};
    end else if (z1 || i2) begin
      sp_y = {s_in, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring step: the remainder stays below twice the divisor, so 25 bits suffice.
  logic        ge;
  logic [24:0] diff;
  logic [24:0] rem_nx;
  logic [25:0] q_nx;

  always_comb begin
    ge     = (rem_r >= {1'b0, div_r});
    diff   = ge ? (rem_r - {1'b0, div_r}) : rem_r;
    rem_nx = {diff[23:0], 1'b0};
    q_nx   = {q_r[24:0], ge};
  end

  // Normalisation, rounding and range check of the finished quotient.
  logic [23:0]       mant;
  logic              guard, sticky, inc;
  logic [24:0]       mant_rnd;
  logic [23:0]       mant_f;
  logic signed [9:0] ex, ex_f;
  logic [31:0]       rnd_y;
  logic              rnd_ovf;

  always_comb begin
    if (q_r[25]) begin
      mant   = q_r[25:2];
      guard  = q_r[1];
      sticky = q_r[0] | (rem_r != 25'd0);
      ex     = ediff_r + 10'sd127;
    end else begin
      mant   = q_r[24:1];
      guard  = q_r[0];
      sticky = (rem_r != 25'd0);
      ex     = ediff_r + 10'sd126;
    end
    inc      = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, inc};
    if (mant_rnd[24]) begin
      mant_f = 24'h800000;
      ex_f   = ex + 10'sd1;
    end else begin
      mant_f = mant_rnd[23:0];
      ex_f   = ex;
    end
    rnd_ovf = 1'b0;
    if (ex_f >= 10'sd255) begin
      rnd_y   = {sign_r, 8'hFF, 23'd0};
      rnd_ovf = 1'b1;
    end else if (ex_f <= 10'sd0) begin
      rnd_y = {sign_r, 31'd0};
    end else begin
      rnd_y = {sign_r, ex_f[7:0], mant_f[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= 32'd0;
      ovf_r       <= 1'b0;
      sign_r      <= 1'b0;
      ediff_r     <= 10'sd0;
      div_r       <= 24'd0;
      rem_r       <= 25'd0;
      q_r         <= 26'd0;
      cnt_r       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            sign_r     <= s_in;
            ediff_r    <= $signed({2'b00, e1}) - $signed({2'b00, e2});
            rem_r      <= {2'b01, m1};
            div_r      <= {1'b1, m2};
            q_r        <= 26'd0;
            cnt_r      <= 5'd0;
            in_ready_r <= 1'b0;
            if (sp_hit) begin
              y_r         <= sp_y;
              ovf_r       <= 1'b0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nx;
          q_r   <= q_nx;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd25) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          y_r         <= rnd_y;
          ovf_r       <= rnd_ovf;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // Result is held until taken; in_ready stays low through the release edge.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: expected {ovf,y} pushed at issue, popped when out_valid appears.
module tb_fdiv_seq;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;

  fdiv_seq_if bus();

  fdiv_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Issues one operation, measures latency counting the accepting edge as edge 1,
  // optionally stalls the result for 'hold' cycles, then releases it.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic eo, input int lat, input int hold);
    int n;
    logic [32:0] got, expv;
    @(negedge clk);
    check({tag, "_in_ready"}, {32'd0, bus.in_ready}, 33'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x1        = a;
    bus.x2        = b;
    exp_q.push_back({eo, ey});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x1       = $urandom();
    bus.x2       = $urandom();
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 33'(n), 33'(lat));
    got  = {bus.ovf, bus.y};
    expv = exp_q.pop_front();
    check({tag, "_result"}, got, expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x1       = 32'h3F800000;
      bus.x2       = 32'h3F800000;
      @(posedge clk);
      #1;
      check({tag, "_hold_y"}, {bus.ovf, bus.y}, expv);
      check({tag, "_hold_ready"}, {31'd0, bus.in_ready, bus.out_valid}, 33'b01);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_release"}, {31'd0, bus.in_ready, bus.out_valid}, 33'b10);
    check({tag, "_idle_state"}, {31'd0, dbg_state}, 33'd0);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1        = 32'd0;
    bus.x2        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_valid", {31'd0, bus.in_ready, bus.out_valid}, 33'b10);
    check("reset_y_ovf", {bus.ovf, bus.y}, 33'd0);
    @(negedge clk);
    rstn = 1'b1;

    run("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 0);
    run("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, 0);
    run("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1,  0);
    run("inf_by_ninf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1,  0);
    run("overflow",     32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, 28, 0);
    run("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 28, 0);
    run("neg_six_by_two", 32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 28, 0);
    run("two_by_three", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, 28, 0);
    run("neg_unity",    32'h3FC00000, 32'hBFC00000, 32'hBF800000, 1'b0, 28, 0);
    run("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1,  0);
    run("zero_by_zero", 32'h00000000, 32'h80000000, 32'h7FC00000, 1'b0, 1,  0);
    run("nzero_by_neg", 32'h80000000, 32'hC0000000, 32'h00000000, 1'b0, 1,  0);
    run("x_by_inf",     32'h40A00000, 32'h7F800000, 32'h00000000, 1'b0, 1,  0);
    run("ninf_by_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1,  0);
    run("denorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1,  0);
    run("hold_five",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 5);

    // Abort an ordinary divide mid-iteration with a one-edge reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x1       = 32'h3F800000;
    bus.x2       = 32'h40400000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready_valid", {31'd0, bus.in_ready, bus.out_valid}, 33'b10);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 33'(seen), 33'd0);
    run("after_abort",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, 0);

    check("queue_drained", 33'(exp_q.size()), 33'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 The module SHALL have parameter NAN_OUT, default 32'h7FC00000: canonical quiet NaN emitted for every invalid or NaN result.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: x1/x2 valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-006 The module SHALL have port x1, input, 32 bits: IEEE-754 single dividend.
REQ-007 The module SHALL have port x2, input, 32 bits: IEEE-754 single divisor.
REQ-008 The module SHALL have port out_valid, output, 1 bit: y/ovf valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The module SHALL have port y, output, 32 bits: quotient x1/x2.
REQ-011 The module SHALL have port ovf, output, 1 bit: finite operands produced infinity.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, ROUND, DONE; transitions: IDLE->CALC on in_valid&in_ready with ordinary operands, IDLE->DONE on in_valid&in_ready with special operands, CALC->ROUND after iteration 26, ROUND->DONE, DONE->IDLE on out_ready.
REQ-013 On acceptance the block SHALL register x1/x2; later input changes SHALL have no effect until the next acceptance.
REQ-014 An operand with exponent 0 SHALL be treated as signed zero (denormals flushed); the result sign SHALL be s1^s2 except for NaN results.
REQ-015 Special-case precedence SHALL be: any NaN, 0/0 or inf/inf -> NAN_OUT; inf/x -> signed inf; x/0 -> signed inf; 0/x -> signed zero; x/inf -> signed zero; ovf=0 in every special case.
REQ-016 CALC SHALL run a restoring division: remainder initialised to {1,m1}, divisor {1,m2}; each cycle q bit = (rem>=div), rem = (rem - q*div)<<1; exactly 26 cycles, MSB first, producing q[25:0].
REQ-017 In ROUND, if q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0), exp=e1-e2+127; otherwise mant=q[24:1], guard=q[0], sticky=(rem!=0), exp=e1-e2+126.
REQ-018 Rounding SHALL be round-to-nearest-even: increment when guard&(sticky|mant[0]); a mantissa carry-out SHALL set mant=1.0 and increment exp.
REQ-019 The exponent SHALL be computed signed with at least 10 bits; exp>=255 -> y=signed inf with ovf=1; exp<=0 -> y=signed zero with ovf=0.
REQ-020 out_valid SHALL assert on the 28th rising edge after the accepting edge for ordinary operands, and on the 1st edge after it for special operands.
REQ-021 y and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 out_valid&out_ready SHALL return the FSM to IDLE; in_valid in that same cycle SHALL NOT be accepted, since in_ready is low in DONE.

Reset
REQ-023 With rstn low at a rising edge, the next state SHALL be IDLE with in_ready=1, out_valid=0, y=0, ovf=0, and internal quotient, remainder and counter cleared.
REQ-024 Reset in any state, including mid-CALC, SHALL abort the operation and produce no out_valid for it.

Verification
REQ-025 Bench SHALL check x1=0x40C00000, x2=0x40000000 -> y=0x40400000, ovf=0, out_valid exactly 28 edges after acceptance.
REQ-026 Bench SHALL check x1=0x3F800000, x2=0x40400000 -> y=0x3EAAAAAB, covering round-up.
REQ-027 Bench SHALL check x1=0x3F800000, x2=0x00000000 -> y=0x7F800000, ovf=0, out_valid 1 edge after acceptance; and x1=0x7F800000, x2=0xFF800000 -> y=0x7FC00000.
REQ-028 Bench SHALL check x1=0x7F7FFFFF, x2=0x3F000000 -> y=0x7F800000, ovf=1; and x1=0x00800000, x2=0x7F000000 -> y=0x00000000, ovf=0.
REQ-029 Bench SHALL check out_ready held low for 5 cycles in DONE -> y stable and in_ready=0 throughout; acceptance occurs only after out_ready.
REQ-030 Bench SHALL check rstn low for one edge at CALC iteration 10 -> next cycle in_ready=1, out_valid=0; a new 6.0/2.0 then completes correctly.
